// File: rtl/imem_responder.sv
// imem_responder: answers instruction-fetch requests with the 32-bit word at a
// byte address after WAIT_CYCLES wait states. It flags misaligned or out-of-range
// addresses, drops in-flight work on flush, and offers a backdoor load port.
// Optional feature macro: IMEM_PREFETCH_EN adds a one-entry next-word buffer.
// With this buffer, a fetch of A+4 that follows a fetch of A skips the wait states.
// Response registers update at the end of the RESP cycle. As a result, rsp_valid
// pulses in the cycle after RESP.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_WORD    = 32'hC800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_start_state;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_cnt_nxt;
  logic [3:0]    w_start_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_hit;
  logic          w_fault;
  logic          w_load_wr;
  logic          w_rsp_fire;
  logic [31:0]   w_rd_data;
  logic [31:0]   w_rsp_word;
  logic          w_unused_load;

  // The low two load address bits carry no information for word writes.
  assign w_unused_load = &{1'b0, load_addr[1:0]};

  assign req_ready = ((r_state == ST_IDLE) || (r_state == ST_RESP)) &&
                     !load_en && !flush && !rst;
  assign w_accept  = req_valid && req_ready;

  assign w_fault   = (r_addr[1:0] != 2'b00) ||
                     ({2'b00, r_addr[31:2]} >= DEPTH_WORDS);

  assign w_load_wr = load_en && (r_state == ST_IDLE) &&
                     ({2'b00, load_addr[31:2]} < DEPTH_WORDS);

  assign w_rsp_fire = (r_state == ST_RESP) && !flush;
  assign w_rd_data  = r_mem[r_addr[AW+1:2]];

`ifdef IMEM_PREFETCH_EN
  logic          r_pf_valid;
  logic [31:0]   r_pf_tag;
  logic [31:0]   r_pf_data;
  logic          r_hit;
  logic          w_next_in_range;
  logic [AW-1:0] w_next_idx;

  assign w_hit           = r_pf_valid && (req_addr == r_pf_tag);
  assign w_next_in_range = (({2'b00, r_addr[31:2]} + 32'd1) < DEPTH_WORDS);
  assign w_next_idx      = r_addr[AW+1:2] + AW'(1);
  assign w_rsp_word      = r_hit ? r_pf_data : w_rd_data;

  // Next-word buffer: refill with A+4 after each good response; drop it on flush or load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_valid <= 1'b0;
      r_pf_tag   <= '0;
      r_pf_data  <= '0;
    end else if (flush || w_load_wr) begin
      r_pf_valid <= 1'b0;
    end else if (w_rsp_fire && !w_fault && w_next_in_range) begin
      r_pf_valid <= 1'b1;
      r_pf_tag   <= r_addr + 32'd4;
      r_pf_data  <= r_mem[w_next_idx];
    end
  end

  // Remember whether the current access is served from the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= 1'b0;
    end else if (w_accept) begin
      r_hit <= w_hit;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_rsp_word = w_rd_data;
`endif

  // Decide the first state of a new access: buffer hits and zero-wait go straight to RESP.
  always_comb begin
    w_start_state = ST_WAIT;
    w_start_cnt   = 4'(WAIT_CYCLES);
    if (w_hit || (WAIT_CYCLES == 0)) begin
      w_start_state = ST_RESP;
      w_start_cnt   = 4'd0;
    end
  end

  // Next-state logic: flush overrides everything; RESP may chain straight into a new access.
  always_comb begin
    // NOTE: every signal this block drives gets a default first; without them a missed branch would infer a latch.
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (flush) begin
      w_state_nxt    = ST_IDLE;
      w_wait_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt    = w_start_state;
            w_wait_cnt_nxt = w_start_cnt;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt <= 4'd1) begin
            w_state_nxt    = ST_RESP;
            w_wait_cnt_nxt = 4'd0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (w_accept) begin
            w_state_nxt    = w_start_state;
            w_wait_cnt_nxt = w_start_cnt;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // State, wait counter and latched request address.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_addr <= req_addr;
      end
    end
  end

  // Backdoor write into the instruction array; honoured only while idle.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents persist across rst and are loaded through the backdoor.
    if (w_load_wr) begin
      r_mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  // Response registers: pulse valid once per RESP; data and fault hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_WORD;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        rsp_fault <= w_fault;
        rsp_instr <= w_fault ? NOP_WORD : w_rsp_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder. Three instances run with WAIT_CYCLES = 0, 1 and 3.
// All three share one stimulus. Each check looks at the outputs of the instance it targets.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'hC800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        flush;
  logic        load_en;
  logic [31:0] req_addr;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1, index 2: WAIT_CYCLES=3.
  logic        req_ready_a [3];
  logic        rsp_valid_a [3];
  logic [31:0] rsp_instr_a [3];
  logic        rsp_fault_a [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[0]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_a[0]),
    .rsp_instr(rsp_instr_a[0]), .rsp_fault(rsp_fault_a[0]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[1]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_a[1]),
    .rsp_instr(rsp_instr_a[1]), .rsp_fault(rsp_fault_a[1]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[2]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_a[2]),
    .rsp_instr(rsp_instr_a[2]), .rsp_fault(rsp_fault_a[2]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Latency counts negedges after the accept edge. Response after edge t+1+W gives 2+W.
  task automatic fetch(input string name, input int k, input logic [31:0] addr,
                       input logic [31:0] exp_instr, input logic exp_fault, input int exp_lat);
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check({name, "_ready"}, 32'(req_ready_a[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_a[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_instr"}, rsp_instr_a[k], exp_instr);
    check({name, "_fault"}, 32'(rsp_fault_a[k]), 32'(exp_fault));
    @(negedge clk);
    check({name, "_pulse_one"}, 32'(rsp_valid_a[k]), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    logic [31:0] exp_chain [3];
    int pf_lat;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;

    vecs[0] = '{1, 32'h0000_0008, 32'h1234_5678, 1'b0, 3};
    vecs[1] = '{1, 32'h0000_0006, NOP,           1'b1, 3};
    vecs[2] = '{1, 32'h0000_1000, NOP,           1'b1, 3};
    vecs[3] = '{1, 32'h0000_0FFC, 32'hBEEF_0FFC, 1'b0, 3};
    vecs[4] = '{0, 32'h0000_0008, 32'h1234_5678, 1'b0, 2};
    vecs[5] = '{0, 32'h0000_0000, 32'hA000_0000, 1'b0, 2};
    vecs[6] = '{0, 32'h0000_0007, NOP,           1'b1, 2};
    vecs[7] = '{2, 32'h0000_0014, 32'hA000_0005, 1'b0, 5};
    vecs[8] = '{1, 32'h0000_0003, NOP,           1'b1, 3};

    // Reset values while rst is held.
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(rsp_valid_a[k]), 32'd0);
      check($sformatf("rst_instr%0d", k), rsp_instr_a[k], NOP);
      check($sformatf("rst_fault%0d", k), 32'(rsp_fault_a[k]), 32'd0);
      check($sformatf("rst_ready%0d", k), 32'(req_ready_a[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Preload: the out-of-range write at 0x1000 must not alias onto word 0.
    for (int i = 0; i < 32; i++) do_load(32'(4 * i), 32'hA000_0000 + 32'(i));
    do_load(32'h0000_0008, 32'h1234_5678);
    do_load(32'h0000_0FFC, 32'hBEEF_0FFC);
    do_load(32'h0000_1000, 32'hDEAD_DEAD);
    repeat (2) @(negedge clk);

    // Table-driven single fetches.
    for (int i = 0; i < 9; i++) begin
      fetch($sformatf("v%0d", i), vecs[i].k, vecs[i].addr, vecs[i].exp_instr,
            vecs[i].exp_fault, vecs[i].exp_lat);
    end

    // Flush in the WAIT cycle after accepting 0x10, with req_valid still high.
    // The W=0 instance is in RESP in that cycle, so its pulse must be suppressed too.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(req_ready_a[0]), 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    seen = rsp_valid_a[0] | rsp_valid_a[1] | rsp_valid_a[2];
    repeat (7) begin
      @(negedge clk);
      seen |= rsp_valid_a[0] | rsp_valid_a[1] | rsp_valid_a[2];
    end
    check("flush_drop", 32'(seen), 32'd0);
    fetch("after_flush", 1, 32'h0000_0020, 32'hA000_0008, 1'b0, 3);

    // Chained requests on the W=0 instance: three back-to-back pulses.
    exp_chain[0] = 32'hA000_0000;
    exp_chain[1] = 32'hA000_0001;
    exp_chain[2] = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    check("chain_first_quiet", 32'(rsp_valid_a[0]), 32'd0);
    req_addr = 32'h0000_0004;
    #1;
    check("chain_ready_in_resp", 32'(req_ready_a[0]), 32'd1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) req_addr = 32'h0000_0008;
      else req_valid = 1'b0;
      check($sformatf("chain%0d_valid", i), 32'(rsp_valid_a[0]), 32'd1);
      check($sformatf("chain%0d_instr", i), rsp_instr_a[0], exp_chain[i]);
    end
    @(negedge clk);
    check("chain_end", 32'(rsp_valid_a[0]), 32'd0);
    repeat (8) @(negedge clk);

    // Load strobe while in RESP (W=0) or WAIT (others) must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'h0000_0000;
    load_data = 32'hBAD0_BAD0;
    @(negedge clk);
    load_en = 1'b0;
    repeat (8) @(negedge clk);
    fetch("load_in_resp", 0, 32'h0000_0000, 32'hA000_0000, 1'b0, 2);

    // Asynchronous reset pulse between edges while accesses are in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0014;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid_a[2]), 32'd0);
    check("arst_instr_w1", rsp_instr_a[1], NOP);
    check("arst_instr_w3", rsp_instr_a[2], NOP);
    check("arst_fault_w1", 32'(rsp_fault_a[1]), 32'd0);
    check("arst_ready", 32'(req_ready_a[1]), 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= rsp_valid_a[0] | rsp_valid_a[1] | rsp_valid_a[2];
    end
    check("arst_no_rsp", 32'(seen), 32'd0);
    fetch("post_rst", 1, 32'h0000_0008, 32'h1234_5678, 1'b0, 3);

    // Sequential fetch on W=3: 0x4 right after 0x0 hits the buffer when enabled.
`ifdef IMEM_PREFETCH_EN
    pf_lat = 2;
`else
    pf_lat = 5;
`endif
    fetch("pf_a0", 2, 32'h0000_0000, 32'hA000_0000, 1'b0, 5);
    fetch("pf_a4", 2, 32'h0000_0004, 32'hA000_0001, 1'b0, pf_lat);
    fetch("pf_a40", 2, 32'h0000_0040, 32'hA000_0010, 1'b0, 5);
    fetch("pf_a4_miss", 2, 32'h0000_0004, 32'hA000_0001, 1'b0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
